// File: rtl/aftab_byte_store_buffer.sv
// Byte store buffer between the DAWU and a byte-wide memory: circular FIFO plus two-state drain FSM.
// Optional sticky push-while-full flag is built when AFTAB_SBUF_OVF_EN is defined.
module aftab_byte_store_buffer #(
  parameter int size  = 32,
  parameter int depth = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pushByte,
  input  logic [size-1:0] addrIn,
  input  logic [7:0]      dataIn,
  output logic            full,
  output logic            empty,
  output logic [size-1:0] memAddr,
  output logic [7:0]      memData,
  output logic            memWrite,
  input  logic            memReady
`ifdef AFTAB_SBUF_OVF_EN
  ,
  output logic            overflowFlag
`endif
);

  localparam int AW = $clog2(depth);

  typedef enum logic {IDLE, WRITE} state_t;

  state_t          state, state_nxt;
  logic [size-1:0] addr_q [depth];
  logic [7:0]      data_q [depth];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     count, count_nxt;
  logic            push, pop;

  // Status comes only from the registered count, so the DAWU stall has no path from pushByte/memReady.
  assign full  = (count == (AW+1)'(depth));
  assign empty = (count == '0);
  assign push  = pushByte & ~full;
  assign pop   = (state == WRITE) & memReady;

  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr] <= addrIn;
      data_q[wr_ptr] <= dataIn;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      state  <= IDLE;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (count != '0) state_nxt = WRITE;
      WRITE:   if (pop && count_nxt == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Head entry is gated so the memory bus reads zero whenever no write is offered.
  assign memWrite = (state == WRITE);
  assign memAddr  = memWrite ? addr_q[rd_ptr] : '0;
  assign memData  = memWrite ? data_q[rd_ptr] : '0;

`ifdef AFTAB_SBUF_OVF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                 overflowFlag <= 1'b0;
    else if (pushByte && full) overflowFlag <= 1'b1;
  end
`endif

endmodule

// File: doc/aftab_byte_store_buffer.md
AFTAB_BYTE_STORE_BUFFER -- requirements
Module: aftab_byte_store_buffer

Interface
REQ-001 Parameter: size, 32, address width in bits.
REQ-002 Parameter: depth, 4, number of buffer entries; power of two, minimum 2.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; 0 = reset.
REQ-005 pushByte  input  1  DAWU byte-store request, qualified by addrIn and dataIn.
REQ-006 addrIn  input  size  byte address from DAWU.
REQ-007 dataIn  input  8  store byte from DAWU.
REQ-008 full  output  1  buffer holds depth entries; DAWU controller stalls while high.
REQ-009 empty  output  1  buffer holds zero entries; all stores retired to memory.
REQ-010 memAddr  output  size  head-entry address to byte-wide memory.
REQ-011 memData  output  8  head-entry byte to memory.
REQ-012 memWrite  output  1  write request to memory.
REQ-013 memReady  input  1  memory accepted the current write this cycle.
REQ-014 overflowFlag  output  1  sticky push-while-full error; present only under REQ-032.

Function
REQ-015 Storage: circular FIFO of depth entries, each {addr[size-1:0], data[7:0]}, with log2(depth)-bit write pointer, read pointer, and log2(depth)+1-bit count.
REQ-016 Push: entry written at write pointer and write pointer incremented when pushByte=1 and full=0.
REQ-017 pushByte=1 while full=1: entry dropped; pointers and count unchanged.
REQ-018 full = (count == depth); empty = (count == 0); both derived from registered count, no combinational path from pushByte or memReady.
REQ-019 Pointers wrap from depth-1 to 0 with no gap.
REQ-020 Drain FSM states: IDLE, WRITE.
REQ-021 IDLE: memWrite=0; moves to WRITE on the first edge where count != 0.
REQ-022 WRITE: memWrite=1; memAddr and memData = head entry, held stable until memReady=1.
REQ-023 WRITE with memReady=1: head popped, read pointer incremented; stays in WRITE if count after the update is nonzero, otherwise goes to IDLE.
REQ-024 Back-to-back writes: a single-cycle memReady pulse retires exactly one entry; continuous memReady retires one entry per cycle.
REQ-025 memReady ignored in IDLE.
REQ-026 Same-cycle push and pop with 0<count<depth: count unchanged, both pointers advance.
REQ-027 Same-cycle push and pop at full: push rejected per REQ-017; pop completes; count becomes depth-1.
REQ-028 First-in latency: push accepted at edge N into an empty buffer gives memWrite=1 after edge N+1.
REQ-029 Entries retired strictly in push order; addr and data never modified in the buffer.

Reset
REQ-030 rst=0 immediately forces FSM=IDLE, pointers=0, count=0, memWrite=0, full=0, empty=1, memAddr=0, memData=0, and overflowFlag=0 if present.
REQ-031 Reset during WRITE abandons the in-flight write and discards all entries; no memWrite after release until a new push.

Configuration
REQ-032 Macro AFTAB_SBUF_OVF_EN defined: overflowFlag port present; set at the edge where pushByte=1 and full=1; cleared only by reset.
REQ-033 Macro AFTAB_SBUF_OVF_EN undefined: overflowFlag port and logic absent; REQ-017 drop behaviour unchanged.

Verification
REQ-034 Reset, then pushByte once with addrIn=0x1000_0003, dataIn=0xA5, memReady=1 -> memWrite=1 one cycle after the push, memAddr=0x1000_0003, memData=0xA5; empty=1 after retirement.
REQ-035 memReady=0, push 4 bytes 0x11..0x44 at addresses 0x200..0x203 -> full=1 after the 4th push; 5th push 0x55 dropped; overflowFlag=1 when AFTAB_SBUF_OVF_EN is defined; after memReady=1, output order is 0x11, 0x22, 0x33, 0x44.
REQ-036 memReady toggling 1,0,1,0 over a 3-entry drain -> memAddr/memData stable while memReady=0; exactly 3 writes observed.
REQ-037 Full buffer with pushByte=1 and memReady=1 in the same cycle -> count=3, full=0, pushed byte not stored.
REQ-038 Continuous push and memReady for 10 cycles, addresses 0x0..0x9 -> pointer wrap; memory sees 0x0..0x9 in order; count never exceeds 2.
REQ-039 rst=0 asserted mid-WRITE with 3 entries -> memWrite=0 and empty=1 without waiting for a clock edge; no writes after release.
